adder_tree: RTL and testbench

Pipelined binary adder tree that sums `PARALLEL` signed lanes packed into one input bus into a single full-precision result. It sits in the neuron datapath after the parallel multipliers and reduces the products to one partial sum per clock. Throughput is one new input vector per cycle. The result appears a fixed number of cycles later, with no handshake.

---
 rtl/adder_tree_pkg.sv | 26 ++
 rtl/adder_tree_level.sv | 37 +++
 rtl/adder_tree.sv | 74 +++++++
 tb/tb_adder_tree.sv | 134 +++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared sizing helpers for the pipelined adder tree.
//   tree_levels(parallel)         - number of pairwise-add levels ($clog2)
//   level_width(data_width, lvl)  - lane width at the output of level lvl
//   padded_lanes(parallel)        - lane count rounded up to a power of two
//   DEFAULT_PADDED_LANES          - padded lane count for the default 8 lanes
package adder_tree_pkg;

    localparam int unsigned DEFAULT_PARALLEL = 8;

    function automatic int unsigned tree_levels(input int unsigned parallel);
        return $clog2(parallel);
    endfunction

    // Every level sign-extends by one bit, so nothing can overflow.
    function automatic int unsigned level_width(input int unsigned data_width,
                                                input int unsigned level);
        return data_width + level;
    endfunction

    function automatic int unsigned padded_lanes(input int unsigned parallel);
        return 32'd1 << tree_levels(parallel);
    endfunction

    localparam int unsigned DEFAULT_PADDED_LANES = padded_lanes(DEFAULT_PARALLEL);

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered stage of pairwise signed adds.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears the stage register
//   din    - 2*PAIRS signed lanes of IN_WIDTH bits, lane k at din[k*IN_WIDTH +: IN_WIDTH]
//   dout   - PAIRS signed sums of IN_WIDTH+1 bits; sum p = lane 2p + lane 2p+1
module adder_tree_level #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned PAIRS    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [2*PAIRS*IN_WIDTH-1:0]     din,
    output logic [PAIRS*(IN_WIDTH+1)-1:0]   dout
);

    localparam int unsigned OW = IN_WIDTH + 1;

    logic [PAIRS*OW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int unsigned p = 0; p < PAIRS; p++) begin
            // Size-casting a signed operand sign-extends it to OW bits.
            sum[p*OW +: OW] = OW'($signed(din[(2*p)*IN_WIDTH +: IN_WIDTH]))
                            + OW'($signed(din[(2*p+1)*IN_WIDTH +: IN_WIDTH]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else begin
            dout <= sum;
        end
    end

endmodule

// File: rtl/adder_tree.sv
// adder_tree: pipelined binary adder tree reducing PARALLEL signed lanes to
// one full-precision sum per clock.
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears every pipeline register
//   din    - PARALLEL packed signed lanes, lane k at din[k*DATA_WIDTH +: DATA_WIDTH]
//   dout   - signed sum, DATA_WIDTH+$clog2(PARALLEL) bits
// Latency is $clog2(PARALLEL) cycles. Build option ADDER_TREE_IN_REG_EN adds an
// input register bank in front of level 1 (latency +1).
module adder_tree
    import adder_tree_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARALLEL   = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [DATA_WIDTH*PARALLEL-1:0]          din,
    output logic [DATA_WIDTH+$clog2(PARALLEL)-1:0]  dout
);

    localparam int unsigned LEVELS = tree_levels(PARALLEL);
    localparam int unsigned PADDED = padded_lanes(PARALLEL);

    logic [PADDED*DATA_WIDTH-1:0] din_pad;
    logic [PADDED*DATA_WIDTH-1:0] lvl0;

    // Missing lanes up to the next power of two are tied to zero.
    if (PADDED > PARALLEL) begin : g_pad
        assign din_pad = {{((PADDED-PARALLEL)*DATA_WIDTH){1'b0}}, din};
    end else begin : g_nopad
        assign din_pad = din;
    end

`ifdef ADDER_TREE_IN_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl0 <= '0;
        end else begin
            lvl0 <= din_pad;
        end
    end
`else
    assign lvl0 = din_pad;
`endif

    // Each level's bus lives in its own generate scope; level l reads the
    // output of scope l-1, so all widths are exact and every bit is used.
    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned IW    = level_width(DATA_WIDTH, l - 1);
        localparam int unsigned PAIRS = PADDED >> l;

        logic [2*PAIRS*IW-1:0]     sin;
        logic [PAIRS*(IW+1)-1:0]   sout;

        if (l == 1) begin : g_first
            assign sin = lvl0;
        end else begin : g_next
            assign sin = g_lvl[l-1].sout;
        end

        adder_tree_level #(
            .IN_WIDTH (IW),
            .PAIRS    (PAIRS)
        ) u_level (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (sin),
            .dout  (sout)
        );
    end

    assign dout = g_lvl[LEVELS].sout;

endmodule

// File: tb/tb_adder_tree.sv
// tb_adder_tree: directed self-checking bench for adder_tree.
// Three instances: 8 lanes (main), 5 lanes (padding) and 2 lanes (one level).
// Honours ADDER_TREE_IN_REG_EN by expecting one extra cycle of latency.
module tb_adder_tree;

`ifdef ADDER_TREE_IN_REG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT  = 3 + EXTRA;   // 8 and 5 lanes
    localparam int LAT2 = 1 + EXTRA;   // 2 lanes

    logic               clk;
    logic               rst_n;
    logic [63:0]        din8;
    logic signed [10:0] dout8;
    logic [39:0]        din5;
    logic signed [10:0] dout5;
    logic [15:0]        din2;
    logic signed [8:0]  dout2;

    int n_cmp = 0;
    int n_err = 0;

    adder_tree #(.DATA_WIDTH(8), .PARALLEL(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .din(din8), .dout(dout8));
    adder_tree #(.DATA_WIDTH(8), .PARALLEL(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .din(din5), .dout(dout5));
    adder_tree #(.DATA_WIDTH(8), .PARALLEL(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din(din2), .dout(dout2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] all8(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] vec [4];
    int          vexp [4];
    int          e;

    initial begin
        vec[0] = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};  vexp[0] = 36;
        vec[1] = all8(8'h7F);                                        vexp[1] = 1016;
        vec[2] = all8(8'h80);                                        vexp[2] = -1024;
        vec[3] = all8(8'hFF);                                        vexp[3] = -8;

        // Reset state, checked before any clock edge.
        rst_n = 1'b0;
        din8  = '0;
        din5  = '0;
        din2  = '0;
        #2;
        check("reset_dout8", dout8, 0);
        check("reset_dout5", dout5, 0);
        check("reset_dout2", dout2, 0);

        // Held vectors from release: 8x5, {1,2,3,4,-5}, {3,4}.
        din8 = all8(8'd5);
        din5 = {8'hFB, 8'd4, 8'd3, 8'd2, 8'd1};
        din2 = {8'd4, 8'd3};
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 1; s <= LAT + 1; s++) begin
            step();
            check("hold5_dout8", dout8, (s >= LAT)  ? 40 : 0);
            check("p5_dout",     dout5, (s >= LAT)  ? 5  : 0);
            check("p2_dout",     dout2, (s >= LAT2) ? 7  : 0);
        end

        // Ramp: vector i driven after edge i appears after edge i+LAT.
        din8 = all8(8'd0);
        for (int s = 1; s <= 19 + LAT; s++) begin
            step();
            check("ramp_dout8", dout8, (s < LAT) ? 40 : 8 * (s - LAT));
            if (s <= 19) din8 = all8(8'(s));
        end

        // Boundary vectors back to back.
        din8 = vec[0];
        for (int s = 1; s <= 3 + LAT; s++) begin
            step();
            check("vec_dout8", dout8, (s < LAT) ? 152 : vexp[s - LAT]);
            if (s < 4) din8 = vec[s];
        end

        // Asynchronous reset mid-stream.
        din8 = all8(8'd5);
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_dout8", dout8, 0);
        check("async_rst_dout5", dout5, 0);
        check("async_rst_dout2", dout2, 0);
        din8 = all8(8'd3);
        step();
        check("in_rst_dout8", dout8, 0);
        @(negedge clk);
        rst_n = 1'b1;
        din8  = all8(8'd2);
        e = 0;
        for (int s = 1; s <= LAT; s++) begin
            step();
            e = s;
            check("post_rst_dout8", dout8, (s >= LAT)  ? 16 : 0);
            check("post_rst_dout2", dout2, (s >= LAT2) ? 7  : 0);
        end
        check("post_rst_dout5", dout5, (e >= LAT) ? 5 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
